// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to the renderer; rgb_test exists only with VGA_TEST_PATTERN_EN.
interface vga_timing_gen_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic       tick_1ms;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb_test;
  modport master (output p_tick, x, y, video_on, hsync, vsync, line_start, frame_start, tick_1ms, rgb_test);
  modport slave  (input  p_tick, x, y, video_on, hsync, vsync, line_start, frame_start, tick_1ms, rgb_test);
`else
  modport master (output p_tick, x, y, video_on, hsync, vsync, line_start, frame_start, tick_1ms);
  modport slave  (input  p_tick, x, y, video_on, hsync, vsync, line_start, frame_start, tick_1ms);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing, frame/line pulses and 1 ms game tick; VGA_TEST_PATTERN_EN adds a colour-bar output.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int CLK_FREQ_HZ = 100000000
) (
  input logic clk,
  input logic reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MS_CNT  = CLK_FREQ_HZ / 1000;
  localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int MW      = MS_CNT > 1 ? $clog2(MS_CNT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [MW-1:0] MS_LAST  = MW'(MS_CNT - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] XA     = 10'(H_ACTIVE);
  localparam logic [9:0] YA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [DW-1:0] r_div, w_div_nx;
  logic [MW-1:0] r_ms;
  logic [9:0]    r_x, r_y, w_x_nx, w_y_nx;
  logic          r_p_tick, r_video_on, r_hsync, r_vsync, r_line_start, r_frame_start, r_tick_1ms;
  logic          w_x_wrap, w_video_nx;
  // Display outputs are derived from next-state x/y so they stay aligned with the counters.
  always_comb begin
    w_div_nx   = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_x_wrap   = r_p_tick && (r_x == X_LAST);
    w_x_nx     = !r_p_tick ? r_x : w_x_wrap ? '0 : r_x + 10'd1;
    w_y_nx     = !w_x_wrap ? r_y : (r_y == Y_LAST) ? '0 : r_y + 10'd1;
    w_video_nx = (w_x_nx < XA) && (w_y_nx < YA);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div         <= '0;
      r_ms          <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_p_tick      <= 1'b0;
      r_video_on    <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_tick_1ms    <= 1'b0;
    end else begin
      r_div         <= w_div_nx;
      r_p_tick      <= (w_div_nx == DIV_LAST);
      r_x           <= w_x_nx;
      r_y           <= w_y_nx;
      r_video_on    <= w_video_nx;
      r_hsync       <= (w_x_nx >= HS_BEG && w_x_nx <= HS_END) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_y_nx >= VS_BEG && w_y_nx <= VS_END) ? SYNC_POL : ~SYNC_POL;
      r_line_start  <= w_x_wrap;
      r_frame_start <= w_x_wrap && (r_y == Y_LAST);
      r_ms          <= (r_ms == MS_LAST) ? '0 : r_ms + 1'b1;
      r_tick_1ms    <= (r_ms == MS_LAST);
    end
  end
  assign vga.p_tick      = r_p_tick;
  assign vga.x           = r_x;
  assign vga.y           = r_y;
  assign vga.video_on    = r_video_on;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;
  assign vga.tick_1ms    = r_tick_1ms;
`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8) > 0 ? H_ACTIVE / 8 : 1;
  logic [11:0] r_rgb;
  logic [2:0]  w_bar;
  // Bar index bits map straight onto inverted R/G/B nibbles: bit1->R, bit2->G, bit0->B.
  assign w_bar = 3'(w_x_nx / 10'(BAR_W));
  always_ff @(posedge clk) begin
    if (!reset) r_rgb <= '0;
    else        r_rgb <= w_video_nx ? {{4{~w_bar[1]}}, {4{~w_bar[2]}}, {4{~w_bar[0]}}} : '0;
  end
  assign vga.rgb_test = r_rgb;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized checks of vga_timing_gen against an arithmetic raster model, with shrunk timing parameters.
module tb_vga_timing_gen;
  localparam int D  = 3;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int FREQ = 250000;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int MS = FREQ / 1000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  vga_timing_gen_if vif ();
  vga_timing_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CLK_FREQ_HZ(FREQ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga(vif)
  );
  // n = clock edges seen since reset release
  always @(posedge clk) n <= reset ? n + 1 : 0;
  logic [26:0] obs;
  assign obs = {vif.p_tick, vif.x, vif.y, vif.video_on, vif.hsync, vif.vsync,
                vif.line_start, vif.frame_start, vif.tick_1ms};
  function automatic int pix(int m);
    return m / D - (D == 1 ? 1 : 0);
  endfunction
  function automatic logic [26:0] model(int m);
    int p, x, y;
    logic ls;
    if (m == 0) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000};
    p  = pix(m);
    x  = p % HT;
    y  = (p / HT) % VT;
    ls = (m >= 2) && (pix(m) != pix(m - 1)) && (x == 0);
    return {(m % D) == D - 1, 10'(x), 10'(y), (x < HA) && (y < VA),
            !(x >= HA + HF && x < HA + HF + HS), !(y >= VA + VF && y < VA + VF + VS),
            ls, ls && (y == 0), (m % MS) == 0};
  endfunction
`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [11:0] rgb_model(int m);
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    int p, x, y;
    if (m == 0) return 12'h000;
    p = pix(m);
    x = p % HT;
    y = (p / HT) % VT;
    return (x < HA && y < VA) ? bars[x / (HA / 8)] : 12'h000;
  endfunction
`endif
  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== model(0)) begin
      errors++;
      $display("FAIL reset_state obs=%h exp=%h", obs, model(0));
    end
    @(negedge clk);
    checks++;
    if (vif.video_on !== 1'b1 || vif.frame_start !== 1'b0 || vif.x !== 10'd0 || vif.y !== 10'd0) begin
      errors++;
      $display("FAIL reset_release video_on=%b frame_start=%b x=%0d y=%0d exp 1 0 0 0",
               vif.video_on, vif.frame_start, vif.x, vif.y);
    end
  endtask
  task automatic test_line();
    int hs_low = 0;
    do_reset();
    repeat (D * HT) begin
      @(negedge clk);
      hs_low += (vif.hsync == 1'b0) ? 1 : 0;
      checks++;
      if (obs !== model(n)) begin
        errors++;
        $display("FAIL line n=%0d obs=%h exp=%h", n, obs, model(n));
      end
    end
    checks++;
    if (hs_low != D * HS) begin
      errors++;
      $display("FAIL hsync_width got=%0d exp=%0d", hs_low, D * HS);
    end
  endtask
  task automatic test_frame();
    int fs = 0, ls = 0, vs_low = 0;
    do_reset();
    repeat (2 * D * HT * VT + 5) begin
      @(negedge clk);
      fs += vif.frame_start ? 1 : 0;
      ls += vif.line_start ? 1 : 0;
      vs_low += (vif.vsync == 1'b0) ? 1 : 0;
      checks++;
      if (obs !== model(n)) begin
        errors++;
        $display("FAIL frame n=%0d obs=%h exp=%h", n, obs, model(n));
      end
    end
    checks++;
    if (fs != 2 || ls != 2 * VT || vs_low != 2 * VS * HT * D) begin
      errors++;
      $display("FAIL frame_counts fs=%0d ls=%0d vs_low=%0d exp %0d %0d %0d",
               fs, ls, vs_low, 2, 2 * VT, 2 * VS * HT * D);
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    repeat (3) begin
      repeat ($urandom_range(50, 900)) begin
        @(negedge clk);
        checks++;
        if (obs !== model(n)) begin
          errors++;
          $display("FAIL mid_run n=%0d obs=%h exp=%h", n, obs, model(n));
        end
      end
      reset = 1'b0;
      repeat (2) begin
        @(negedge clk);
        checks++;
        if (obs !== model(0)) begin
          errors++;
          $display("FAIL mid_reset obs=%h exp=%h", obs, model(0));
        end
      end
      reset = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (obs !== model(n)) begin
          errors++;
          $display("FAIL mid_release n=%0d obs=%h exp=%h", n, obs, model(n));
        end
      end
    end
  endtask
  task automatic test_tick_1ms();
    int ticks = 0;
    do_reset();
    repeat (3 * MS + 3) begin
      @(negedge clk);
      if (vif.tick_1ms) begin
        ticks++;
        checks++;
        if (n != ticks * MS) begin
          errors++;
          $display("FAIL tick_pos got=%0d exp=%0d", n, ticks * MS);
        end
      end
      checks++;
      if (obs !== model(n)) begin
        errors++;
        $display("FAIL tick_run n=%0d obs=%h exp=%h", n, obs, model(n));
      end
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL tick_count got=%0d exp=3", ticks);
    end
  endtask
`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    do_reset();
    checks++;
    if (vif.rgb_test !== 12'h000) begin
      errors++;
      $display("FAIL rgb_reset got=%h exp=000", vif.rgb_test);
    end
    repeat (D * HT * VT + 3) begin
      @(negedge clk);
      checks++;
      if (vif.rgb_test !== rgb_model(n)) begin
        errors++;
        $display("FAIL rgb n=%0d got=%h exp=%h", n, vif.rgb_test, rgb_model(n));
      end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_tick_1ms();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
